// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel emits a registered square wave and a
// one-cycle tick per period; divisor writes take effect at the period boundary while running.
module clk_div_ch #(
  parameter int              DIV_W   = 26,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(48_000_000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_out_o,
  output logic             tick_o
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_act_q, div_act_d, div_shd_q, div_shd_d;
  logic             pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d;
  logic [DIV_W-1:0] hi_m1;
  logic             wrap;

  // High phase is ceil(div/2) so odd divisors spend the extra cycle high.
  assign hi_m1 = div_act_q - (div_act_q >> 1) - DIV_W'(1);
  assign wrap  = (cnt_q == div_act_q - DIV_W'(1));

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (st_q == S_IDLE) begin
      cnt_d     = '0;
      clk_out_d = en_i;
      tick_d    = en_i;
      st_d      = en_i ? S_RUN : S_IDLE;
    end else if (!en_i) begin
      st_d      = S_IDLE;
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (wrap) begin
      cnt_d     = '0;
      clk_out_d = 1'b1;
      tick_d    = 1'b1;
      if (pend_q) begin
        div_act_d = div_shd_q;
        pend_d    = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      if (cnt_q == hi_m1) clk_out_d = 1'b0;
    end
    // Applied after the boundary logic so a same-cycle boundary consumes the older shadow.
    if (wr_i) begin
      if (st_q == S_RUN && en_i) begin
        div_shd_d = wr_div_i;
        pend_d    = 1'b1;
      end else begin
        div_act_d = wr_div_i;
        div_shd_d = wr_div_i;
        pend_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      div_act_q <= RST_DIV;
      div_shd_q <= RST_DIV;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
endmodule

module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 48_000_000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [DIV_W-1:0]  wr_div_i,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic              wr_err_o
);
  localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] wr_div_c;
  logic [31:0]      wr_ch_ext;
  logic             wr_err_q, wr_err_d;

  assign wr_div_c  = (wr_div_i < DIV_W'(2)) ? DIV_W'(2) : wr_div_i;
  // Widened so the range check stays meaningful when NUM_CH is a power of two.
  assign wr_ch_ext = 32'(wr_ch_i);
  assign wr_err_d  = wr_en_i && (wr_ch_ext >= 32'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i[c]),
      .wr_i      (wr_en_i && (wr_ch_ext == 32'(c))),
      .wr_div_i  (wr_div_c),
      .pend_o    (pend_o[c]),
      .clk_out_o (clk_out_o[c]),
      .tick_o    (tick_o[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_err_d;
  end

  assign wr_err_o = wr_err_q;
endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios then random traffic, all checked against a
// period/phase model of each channel.
module tb_clk_div_multi;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int DEF    = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] pend, clk_out, tick;
  logic              wr_err;

  int checks = 0;
  int fails  = 0;

  // Model: phase p within a period of length d; outputs derive from (run, p, d).
  bit m_run [NUM_CH];
  int m_p   [NUM_CH];
  int m_d   [NUM_CH];
  int m_shd [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_err;

  clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .wr_en_i   (wr_en),
    .wr_ch_i   (wr_ch),
    .wr_div_i  (wr_div),
    .pend_o    (pend),
    .clk_out_o (clk_out),
    .tick_o    (tick),
    .wr_err_o  (wr_err)
  );

  always #5 clk = ~clk;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_p[c] = 0; m_d[c] = clampd(DEF); m_shd[c] = clampd(DEF); m_pend[c] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_update();
    for (int c = 0; c < NUM_CH; c++) begin
      bit was_run;
      was_run = m_run[c];
      if (!was_run) begin
        m_p[c] = 0;
        m_run[c] = en[c];
      end else if (!en[c]) begin
        m_run[c] = 0; m_p[c] = 0;
      end else if (m_p[c] == m_d[c] - 1) begin
        m_p[c] = 0;
        if (m_pend[c]) begin m_d[c] = m_shd[c]; m_pend[c] = 0; end
      end else begin
        m_p[c] = m_p[c] + 1;
      end
      if (wr_en && int'(wr_ch) == c) begin
        if (was_run && en[c]) begin
          m_shd[c] = clampd(int'(wr_div)); m_pend[c] = 1;
        end else begin
          m_d[c] = clampd(int'(wr_div)); m_shd[c] = m_d[c]; m_pend[c] = 0;
        end
      end
    end
    m_err = wr_en && (int'(wr_ch) >= NUM_CH);
  endtask

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] ec, et, ep;
    ec = '0; et = '0; ep = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c] = m_run[c] && (m_p[c] < m_d[c] - m_d[c] / 2);
      et[c] = m_run[c] && (m_p[c] == 0);
      ep[c] = m_pend[c];
    end
    chk("clk_out", 8'(clk_out), ec);
    chk("tick",    8'(tick),    et);
    chk("pend",    8'(pend),    ep);
    chk("wr_err",  8'(wr_err),  8'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int ch, input int dv);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = DIV_W'(dv);
    step();
    wr_en = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    rst_n = 1'b0;
    model_reset();
    // reset holds outputs low even with every channel enabled
    en = '1;
    #2;
    check_all();
    steps(2);
    rst_n = 1'b1;
    en = 3'b001;
    steps(12);

    // ch1 written while idle, then run alongside ch0
    wr(1, 5);
    en = 3'b011;
    steps(15);

    // ch0 divisor change mid-period waits for the boundary
    k = 0;
    while (m_p[0] != 1 && k < 10) begin step(); k++; end
    chk("t4_sync", 8'(k < 10), 8'd1);
    wr(0, 6);
    chk("t4_pend", 8'(pend[0]), 8'd1);
    steps(14);

    // clamp of 0 and 1, plus rejected out-of-range channel
    wr(2, 0);
    en = 3'b111;
    steps(8);
    wr(2, 1);
    steps(8);
    wr(3, 7);
    steps(2);

    // drop enable mid high phase, then re-raise
    k = 0;
    while (m_p[0] != 0 && k < 10) begin step(); k++; end
    chk("t6_sync", 8'(k < 10), 8'd1);
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    steps(3);
    wr(1, 9);
    chk("t6_pend", 8'(pend[1]), 8'd1);
    async_reset();
    steps(10);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) en = NUM_CH'($urandom);
      wr_en  = ($urandom_range(0, 4) == 0);
      wr_ch  = CH_W'($urandom_range(0, 3));
      wr_div = DIV_W'($urandom_range(0, 9));
      if ($urandom_range(0, 249) == 0) begin
        wr_en = 1'b0;
        async_reset();
      end else begin
        step();
      end
    end
    wr_en = 1'b0;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
